data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter and access sequencer in front of the single-port `data_mem` data memory (4096 × 32-bit words, 16 KiB). Port 0 is the core load/store unit and port 1 is the debug/DMA master. The block latches one request at a time and drives the memory request, write-enable, address and write-data. It honours the memory's one-cycle synchronous read latency by holding the memory request for two cycles on reads. It returns a single-cycle done pulse with the read data, and rejects out-of-range or misaligned accesses without touching memory.

## Interface
Parameters:
- `ADDR_LIMIT`, default 16384: byte size of the memory. An address ≥ `ADDR_LIMIT` is out of range.
- `ERR_DATA`, default 32'hdead_beef: read data returned on a rejected access.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `p0_req_i`, `p1_req_i`  in  1  request; held high with stable `we`/`addr`/`wdata` until that port's `done_o`.
- `p0_we_i`, `p1_we_i`  in  1  1 = write, 0 = read.
- `p0_addr_i`, `p1_addr_i`  in  32  byte address.
- `p0_wdata_i`, `p1_wdata_i`  in  32  write data.
- `p0_done_o`, `p1_done_o`  out  1  one-cycle completion pulse.
- `p0_err_o`, `p1_err_o`  out  1  valid with `done`; 1 = rejected access.
- `p0_rdata_o`, `p1_rdata_o`  out  32  read data; valid with `done` on reads.
- `mem_req_o`  out  1  to `data_mem` `mem_req_i`.
- `mem_we_o`  out  1  to `data_mem` `write_enable_i`.
- `mem_addr_o`  out  32  to `data_mem` `addr_i`.
- `mem_wdata_o`  out  32  to `data_mem` `write_data_i`.
- `mem_rdata_i`  in  32  from `data_mem` `read_data_o`.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WR, RD0, RD1, RESP.
- **IDLE**
  - If any request is high, select a winner per the arbitration rule.
  - Latch the winner's id, `we`, `addr` and `wdata` into internal registers.
  - If `addr ≥ ADDR_LIMIT` or `addr[1:0] != 0`: set `err`, load `rdata` register = `ERR_DATA`, go to RESP. Memory is not accessed.
  - Otherwise go to WR (we=1) or RD0 (we=0).
- **WR**: `mem_req_o`=1, `mem_we_o`=1, address and data from the latched registers; memory commits at the end of the cycle. Next state: RESP.
- **RD0**: `mem_req_o`=1, `mem_we_o`=0, latched address. Next state: RD1.
- **RD1**: same memory drive as RD0. `mem_rdata_i` is captured into the `rdata` register at the end of the cycle. Next state: RESP.
- **RESP**
  - Granted port: `done_o`=1, `err_o` and `rdata_o` from registers. The non-granted port's outputs stay 0.
  - No arbitration in RESP, so a request still held in that cycle is not re-granted.
  - Next state: IDLE.
- Outside WR/RD0/RD1, all `mem_*_o` outputs are 0.
- `rdata_o` is 0 on writes and at all times other than RESP.
- A pending request on the losing port waits. It is never dropped and never granted twice.

## Timing
- Reset: when `rst_ni`=0 at a rising edge, the FSM goes to IDLE and all outputs and internal registers become 0. The arbitration pointer resets to favour port 0.
- Reset mid-transaction (any state) aborts it with no `done`. A write already in WR commits only if that edge is not a reset edge.
- Latency from request sampled in IDLE (cycle 0):
  - write: `done` in cycle 2.
  - read: `done` in cycle 3.
  - rejected access: `done` in cycle 1.
- Throughput: one access per 3 cycles for writes, one per 4 cycles for reads.
- A requester may raise a new request in the cycle after `done`; it is arbitrated in that IDLE cycle.
- Simultaneous requests in IDLE resolve in the same cycle; there is no idle bubble.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer updates on every grant to favour the other port.
  - With both ports requesting continuously, grants alternate 0,1,0,1, starting with port 0 after reset.
- `DMEM_ARB_RR_EN` undefined: fixed priority. Port 0 always wins a tie, and port 1 can starve. No pointer register is present.

## Test plan
- Port 0 writes 32'h1234_5678 to 0x40, then reads 0x40 → `p0_done_o` in cycle 2 for the write; `p0_done_o` in cycle 3 for the read with `p0_rdata_o`=32'h1234_5678 and `err`=0.
- Port 1 reads 0x4000 (= `ADDR_LIMIT`) → `p1_done_o`, `p1_err_o`=1, `p1_rdata_o`=32'hdead_beef in cycle 1; `mem_req_o` stays 0 throughout.
- Port 0 writes to 0x42 (misaligned) → `err`=1 with `done` in cycle 1, no `mem_req_o`; a later read of 0x40 returns the previous data unchanged.
- Both ports continuously read 0x0 and 0x4:
  - with `DMEM_ARB_RR_EN`: grant order 0,1,0,1 and each done spaced 4 cycles apart;
  - without `DMEM_ARB_RR_EN`: port 1 receives no `done` while port 0 keeps requesting.
- `rst_ni` pulled low during RD1 of a port 0 read → no `p0_done_o`, all outputs 0 next cycle, `busy_o`=0; a re-issued read completes normally.
- Requester holds `req` high through the `done` cycle and drops it in the following cycle → exactly one `done` and one memory access are observed.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and access sequencer in front of the single-port data_mem.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'd16384,
    parameter logic [31:0] ERR_DATA   = 32'hdead_beef
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    output logic        p0_done_o,
    output logic        p0_err_o,
    output logic [31:0] p0_rdata_o,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    output logic        p1_done_o,
    output logic        p1_err_o,
    output logic [31:0] p1_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    // state | meaning
    // IDLE  | arbitrate, latch winner, reject bad addresses
    // WR    | memory write cycle
    // RD0   | memory read request, data not yet valid
    // RD1   | read request held, capture mem_rdata_i at end of cycle
    // RESP  | done pulse to granted port
    typedef enum logic [2:0] {IDLE, WR, RD0, RD1, RESP} state_e;

    state_e      state_q, state_d;
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic        p0_done_q, p0_done_d;
    logic        p1_done_q, p1_done_d;
    logic        p0_err_q, p0_err_d;
    logic        p1_err_q, p1_err_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        gnt_id;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;
    logic        mem_act;
    logic        resp_nxt;

`ifdef DMEM_ARB_RR_EN
    logic ptr_q, ptr_d;
    // On a tie the pointer picks; a lone requester always wins.
    assign gnt_id = p1_req_i & (~p0_req_i | ptr_q);
`else
    assign gnt_id = ~p0_req_i;
`endif

    assign sel_we    = gnt_id ? p1_we_i    : p0_we_i;
    assign sel_addr  = gnt_id ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = gnt_id ? p1_wdata_i : p0_wdata_i;
    assign sel_bad   = (sel_addr >= ADDR_LIMIT) || (sel_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    id_d    = gnt_id;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
`ifdef DMEM_ARB_RR_EN
                    ptr_d   = ~gnt_id;
`endif
                    if (sel_bad) begin
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        rdata_d = '0;
                        state_d = sel_we ? WR : RD0;
                    end
                end
            end
            WR:      state_d = RESP;
            RD0:     state_d = RD1;
            RD1: begin
                rdata_d = mem_rdata_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        mem_act     = (state_d == WR) || (state_d == RD0) || (state_d == RD1);
        resp_nxt    = (state_d == RESP);
        mem_req_d   = mem_act;
        mem_we_d    = (state_d == WR);
        mem_addr_d  = mem_act ? addr_d : '0;
        mem_wdata_d = (state_d == WR) ? wdata_d : '0;
        busy_d      = (state_d != IDLE);
        p0_done_d   = resp_nxt && !id_d;
        p1_done_d   = resp_nxt && id_d;
        p0_err_d    = p0_done_d && err_d;
        p1_err_d    = p1_done_d && err_d;
        p0_rdata_d  = (p0_done_d && !we_d) ? rdata_d : '0;
        p1_rdata_d  = (p1_done_d && !we_d) ? rdata_d : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            p0_done_q   <= 1'b0;
            p1_done_q   <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            p0_done_q   <= p0_done_d;
            p1_done_q   <= p1_done_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
`ifdef DMEM_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign p0_done_o   = p0_done_q;
    assign p1_done_o   = p1_done_q;
    assign p0_err_o    = p0_err_q;
    assign p1_err_o    = p1_err_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter against a transaction-level model
// (grant rule, fixed per-kind latency, reference memory array).
module tb_data_mem_arbiter;

    localparam logic [31:0] LIMIT = 32'd16384;
    localparam logic [31:0] ERRD  = 32'hdead_beef;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        done  [2];
    logic        err   [2];
    logic [31:0] rdata [2];
    logic        mem_req, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    data_mem_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .p0_req_i   (req[0]),
        .p0_we_i    (we[0]),
        .p0_addr_i  (addr[0]),
        .p0_wdata_i (wdata[0]),
        .p0_done_o  (done[0]),
        .p0_err_o   (err[0]),
        .p0_rdata_o (rdata[0]),
        .p1_req_i   (req[1]),
        .p1_we_i    (we[1]),
        .p1_addr_i  (addr[1]),
        .p1_wdata_i (wdata[1]),
        .p1_done_o  (done[1]),
        .p1_err_o   (err[1]),
        .p1_rdata_o (rdata[1]),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy)
    );

    // Behavioural data_mem: one-cycle synchronous read.
    logic [31:0] mem_arr [4096];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) mem_arr[mem_addr[13:2]] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr[13:2]];
        end
    end

    logic [31:0] ref_mem [4096];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            6:       a = LIMIT;
            7:       a = LIMIT - 32'd4;
            8:       a = 32'h40 + 32'($urandom_range(1, 3));
            9:       a = $urandom;
            default: a = 32'h40 + 32'(4 * $urandom_range(0, 7));
        endcase
        return a;
    endfunction

    // Model: the one transaction in flight, and requester bookkeeping.
    bit          t_valid;
    int          t_g, t_len, t_port;
    bit          t_we, t_bad;
    logic [31:0] t_addr, t_wdata, t_rdata;
    int          free_at;
    bit          favour;
    bit          pend [2];
    bit          done_seen [2];
    bit          sat, do_rst, inwin, memwin, donec, ed;
    int          n_rst;
    int          w;
    int          dut_dones [2];
    int          mdl_dones [2];
    logic [31:0] a;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_arr[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0;
            pend[p] = 1'b0; done_seen[p] = 1'b0;
            dut_dones[p] = 0; mdl_dones[p] = 0;
        end
        t_valid = 1'b0; free_at = 0; favour = 1'b0; n_rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    32'(busy), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we",  32'(mem_we), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        for (int p = 0; p < 2; p++) begin
            chk("rst_done",  32'(done[p]), 32'h0);
            chk("rst_err",   32'(err[p]), 32'h0);
            chk("rst_rdata", rdata[p], 32'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 2600; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst_n = 1'b1;
            sat = (cyc >= 1500 && cyc < 1650);

            // A requester drops its request the cycle after its done.
            for (int p = 0; p < 2; p++) begin
                if (done_seen[p]) begin
                    pend[p] = 1'b0; done_seen[p] = 1'b0;
                    req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0;
                end
            end

            inwin  = t_valid && cyc > t_g && cyc <= t_g + t_len;
            memwin = t_valid && !t_bad && cyc > t_g && cyc < t_g + t_len;
            donec  = t_valid && cyc == t_g + t_len;
            chk("busy",      32'(busy), 32'(inwin));
            chk("mem_req",   32'(mem_req), 32'(memwin));
            chk("mem_we",    32'(mem_we), 32'(memwin && t_we));
            chk("mem_addr",  mem_addr, memwin ? t_addr : 32'h0);
            chk("mem_wdata", mem_wdata, (memwin && t_we) ? t_wdata : 32'h0);
            for (int p = 0; p < 2; p++) begin
                ed = donec && (t_port == p);
                chk("done",  32'(done[p]), 32'(ed));
                chk("err",   32'(err[p]), 32'(ed && t_bad));
                chk("rdata", rdata[p], (ed && !t_we) ? t_rdata : 32'h0);
                if (done[p] === 1'b1) dut_dones[p]++;
                if (ed) begin
                    mdl_dones[p]++;
                    done_seen[p] = 1'b1;
                end
            end
            if (donec) t_valid = 1'b0;

            // Occasionally pull reset during RD1 of a good read.
            do_rst = t_valid && !t_bad && !t_we && cyc == t_g + 2 && n_rst < 4
                     && $urandom_range(0, 2) == 0;
            if (do_rst) begin
                rst_n = 1'b0;
                n_rst++;
                t_valid = 1'b0;
                favour = 1'b0;
                free_at = cyc + 1;
            end

            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !done_seen[p] && (sat || $urandom_range(0, 2) == 0)) begin
                    pend[p]  = 1'b1;
                    req[p]   = 1'b1;
                    we[p]    = sat ? 1'b0 : 1'($urandom_range(0, 1));
                    addr[p]  = sat ? (p == 1 ? 32'h4 : 32'h0) : pick_addr();
                    wdata[p] = $urandom;
                end
            end

            if (!do_rst && cyc >= free_at && (pend[0] || pend[1])) begin
`ifdef DMEM_ARB_RR_EN
                w = (pend[0] && pend[1]) ? int'(favour) : (pend[1] ? 1 : 0);
                favour = (w == 0);
`else
                w = pend[0] ? 0 : 1;
`endif
                a       = addr[w];
                t_valid = 1'b1;
                t_g     = cyc;
                t_port  = w;
                t_we    = we[w];
                t_addr  = a;
                t_wdata = wdata[w];
                t_bad   = (a >= LIMIT) || (a[1:0] != 2'b00);
                t_len   = t_bad ? 1 : (t_we ? 2 : 3);
                if (t_bad) t_rdata = ERRD;
                else if (!t_we) t_rdata = ref_mem[a[13:2]];
                else begin
                    t_rdata = 32'h0;
                    ref_mem[a[13:2]] = t_wdata;
                end
                free_at = cyc + t_len + 1;
            end
        end

        chk("p0_done_count", 32'(dut_dones[0]), 32'(mdl_dones[0]));
        chk("p1_done_count", 32'(dut_dones[1]), 32'(mdl_dones[1]));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
